// File: rtl/bios_loader_if.sv
// BIOS word port between bios_loader (master) and system (slave).
// Carries word address/data, write request and the acknowledge.
interface bios_loader_if #(
  parameter int AW = 13
);
  logic [AW-1:0] bios_addr;
  logic [15:0]   bios_din;
  logic          bios_wr;
  logic          bios_req;

  modport master (
    output bios_addr,
    output bios_din,
    output bios_wr,
    input  bios_req
  );

  modport slave (
    input  bios_addr,
    input  bios_din,
    input  bios_wr,
    output bios_req
  );
endinterface

// File: rtl/bios_loader.sv
// Streams an HPS ioctl BIOS download into system's BIOS load port.
// Ports: ioctl_* from HPS, ioctl_wait back-pressure, bus (word port),
// bios_loaded / bios_err status, clk_sys and async active-low reset_n.
module bios_loader #(
  parameter int         AW    = 13,
  parameter int         DEPTH = 8,
  parameter logic [7:0] INDEX = 8'd0
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          bios_loaded,
  output logic [1:0]    bios_err,
  bios_loader_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + 16;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] WAIT_C = CW'(DEPTH - 2);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t        state, state_nxt;
  logic          dl_q, req_q, hold, pend;
  logic [7:0]    lo_byte;
  logic [AW-1:0] lo_addr;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          dl_rise, dl_fall, start_ok;
  logic          start, flush_done;
  logic          in_rng, byte_ev;
  logic          odd_push, even_lat, oor, tail;
  logic          push_req, full, push, drop, pop;
  logic          hold_nxt, wr_nxt;
  logic [EW-1:0] push_ent, head;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign start_ok = dl_rise && (ioctl_index == INDEX);

  assign in_rng   = (ioctl_addr >> (AW + 1)) == 25'd0;
  assign byte_ev  = (state == LOAD) && ioctl_wr;
  assign odd_push = byte_ev && in_rng && ioctl_addr[0];
  assign even_lat = byte_ev && in_rng && !ioctl_addr[0];
  assign oor      = byte_ev && !in_rng;
  // an unpaired even byte is flushed as a zero-padded word
  assign tail     = (state == LOAD) && dl_fall && pend;

  assign push_req = odd_push || tail;
  assign full     = count == FULL_C;
  assign push     = push_req && !full;
  assign drop     = push_req && full;
  assign pop      = bus.bios_wr && bus.bios_req && !req_q;

  assign push_ent = tail ? {lo_addr, 8'h00, lo_byte}
                         : {ioctl_addr[AW:1], ioctl_dout, lo_byte};
  assign head     = mem[rd_ptr];

  // hold blocks re-presentation until the ack is seen low
  assign hold_nxt = pop | (hold & bus.bios_req);
  assign wr_nxt   = (count != '0) && !pop && !hold_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start_ok) state_nxt = LOAD;
      LOAD:       if (dl_fall)  state_nxt = FLUSH;
      FLUSH: begin
        if (count == '0 && !bus.bios_wr && !bus.bios_req)
          state_nxt = DONE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  assign start      = (state_nxt == LOAD) && (state != LOAD);
  assign flush_done = (state == FLUSH) && (state_nxt == DONE);

  always_ff @(posedge clk_sys)
    if (push) mem[wr_ptr] <= push_ent;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      dl_q          <= 1'b0;
      req_q         <= 1'b0;
      hold          <= 1'b0;
      pend          <= 1'b0;
      lo_byte       <= '0;
      lo_addr       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ioctl_wait    <= 1'b0;
      bios_loaded   <= 1'b0;
      bios_err      <= '0;
      bus.bios_wr   <= 1'b0;
      bus.bios_addr <= '0;
      bus.bios_din  <= '0;
    end else begin
      state      <= state_nxt;
      dl_q       <= ioctl_download;
      req_q      <= bus.bios_req;
      ioctl_wait <= count >= WAIT_C;
      if (start) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        count         <= '0;
        pend          <= 1'b0;
        hold          <= 1'b0;
        bios_err      <= '0;
        bios_loaded   <= 1'b0;
        bus.bios_wr   <= 1'b0;
        bus.bios_addr <= '0;
        bus.bios_din  <= '0;
      end else begin
        if (even_lat) begin
          lo_byte <= ioctl_dout;
          lo_addr <= ioctl_addr[AW:1];
          pend    <= 1'b1;
        end
        if (push_req) pend <= 1'b0;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count       <= count + CW'(push) - CW'(pop);
        hold        <= hold_nxt;
        bus.bios_wr <= wr_nxt;
        if (wr_nxt && !bus.bios_wr)
          {bus.bios_addr, bus.bios_din} <= head;
        if (tail)        bios_err[0] <= 1'b1;
        if (oor || drop) bios_err[1] <= 1'b1;
        if (flush_done)  bios_loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bios_loader.sv
// Self-checking bench for bios_loader: HPS byte driver, system ack
// model and a word scoreboard compared as words are presented.
module tb_bios_loader;

  localparam int AW    = 13;
  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait;
  logic        bios_loaded;
  logic [1:0]  bios_err;

  bios_loader_if #(.AW(AW)) bif ();

  bios_loader #(.AW(AW), .DEPTH(DEPTH), .INDEX(8'd0)) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .bios_loaded   (bios_loaded),
    .bios_err      (bios_err),
    .bus           (bif.master)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk_sys) cyc++;

  logic [39:0] sb [$];
  int ack_en = 0, ack_dly = 1, ack_hold = 1;
  int mst = 0, mcnt = 0, fall_cyc = 0;
  logic wr_prev = 1'b0;
  int n_words = 0;
  logic [AW-1:0] last_addr = '0;

  task automatic chk(input string tag, input logic [39:0] obs,
                     input logic [39:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // system model: ack ack_dly negedges after bios_wr, hold ack_hold
  always @(negedge clk_sys) begin
    if (!reset_n || ack_en == 0) begin
      bif.bios_req = 1'b0;
      mst = 0;
    end else begin
      case (mst)
        0: if (bif.bios_wr) begin
          if (ack_dly == 0) begin
            bif.bios_req = 1'b1;
            mcnt = ack_hold - 1;
            mst = 2;
          end else begin
            mcnt = ack_dly - 1;
            mst = 1;
          end
        end
        1: if (mcnt == 0) begin
          bif.bios_req = 1'b1;
          mcnt = ack_hold - 1;
          mst = 2;
        end else mcnt--;
        default: if (mcnt == 0) begin
          bif.bios_req = 1'b0;
          fall_cyc = cyc;
          mst = 0;
        end else mcnt--;
      endcase
    end
  end

  // word monitor
  always @(negedge clk_sys) begin
    if (reset_n && bif.bios_wr && !wr_prev) begin
      n_words++;
      last_addr = bif.bios_addr;
      n_chk++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: word %0h/%0h expected none",
               bif.bios_addr, bif.bios_din);
      end
      if (sb.size() > 0)
        chk("word", {11'd0, bif.bios_addr, bif.bios_din}, sb.pop_front());
    end
    wr_prev = reset_n ? bif.bios_wr : 1'b0;
  end

  function automatic logic [39:0] ent(input int a, input logic [15:0] d);
    return {11'd0, AW'(a), d};
  endfunction

  task automatic put(input int a, input logic [7:0] d, input bit force_);
    int g = 0;
    while (!force_ && ioctl_wait && g < 500) begin
      @(negedge clk_sys);
      g++;
    end
    if (g >= 500) begin
      n_chk++;
      n_fail++;
      $error("FAIL wait_bound: ioctl_wait stuck %0d expected <500", g);
    end
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_loaded(input string tag);
    int g = 0;
    while (!bios_loaded && g < 3000) begin
      @(negedge clk_sys);
      g++;
    end
    chk({tag, "_loaded"}, bios_loaded, 1);
    chk({tag, "_lat"}, (cyc - fall_cyc) <= 2, 1);
  endtask

  function automatic logic [39:0] outs();
    return {6'd0, ioctl_wait, bif.bios_wr, bios_loaded, bios_err,
            bif.bios_addr, bif.bios_din};
  endfunction

  initial begin
    int base, g;
    logic [7:0] lo, hi;
    repeat (3) @(negedge clk_sys);
    chk("rst_outputs", outs(), 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // basic load
    ack_en = 1; ack_dly = 2; ack_hold = 1;
    start_dl(8'd0);
    sb.push_back(ent(0, 16'h2211));
    sb.push_back(ent(1, 16'h4433));
    put(0, 8'h11, 0);
    put(1, 8'h22, 0);
    put(2, 8'h33, 0);
    put(3, 8'h44, 0);
    end_dl();
    wait_loaded("basic");
    chk("basic_err", bios_err, 0);
    chk("basic_sb", sb.size(), 0);

    // back-pressure with no acks
    ack_en = 0;
    start_dl(8'd0);
    chk("bp_loaded_clr", bios_loaded, 0);
    for (int w = 0; w < 9; w++) begin
      if (w < 8) sb.push_back(ent(w, {8'(2*w+2), 8'(2*w+1)}));
      put(2*w, 8'(2*w+1), 1);
      put(2*w+1, 8'(2*w+2), 1);
      if (w == 4) begin
        @(negedge clk_sys);
        chk("bp_wait_5", ioctl_wait, 0);
      end
      if (w == 5) begin
        @(negedge clk_sys);
        chk("bp_wait_6", ioctl_wait, 1);
      end
      if (w == 7) chk("bp_err_8", bios_err, 0);
    end
    chk("bp_err_ovf", bios_err, 2'b10);
    chk("bp_wait_full", ioctl_wait, 1);
    end_dl();
    ack_en = 1; ack_dly = 1; ack_hold = 1;
    wait_loaded("bp");
    chk("bp_err_sticky", bios_err, 2'b10);
    chk("bp_sb", sb.size(), 0);

    // odd length
    start_dl(8'd0);
    sb.push_back(ent(0, 16'hBBAA));
    sb.push_back(ent(1, 16'h00CC));
    put(0, 8'hAA, 0);
    put(1, 8'hBB, 0);
    put(2, 8'hCC, 0);
    end_dl();
    wait_loaded("odd");
    chk("odd_err", bios_err, 2'b01);
    chk("odd_sb", sb.size(), 0);

    // wrong index
    base = n_words;
    start_dl(8'd1);
    for (int i = 0; i < 4; i++) put(i, 8'(i + 8'h60), 0);
    end_dl();
    repeat (10) @(negedge clk_sys);
    chk("widx_nowr", n_words - base, 0);
    chk("widx_loaded", bios_loaded, 1);
    start_dl(8'd0);
    chk("widx_reload_clr", bios_loaded, 0);
    sb.push_back(ent(0, 16'h0201));
    sb.push_back(ent(1, 16'h0403));
    for (int i = 0; i < 4; i++) put(i, 8'(i + 1), 0);
    end_dl();
    wait_loaded("widx");
    chk("widx_err", bios_err, 0);
    chk("widx_sb", sb.size(), 0);

    // reset mid-transfer
    base = n_words;
    start_dl(8'd0);
    for (int w = 0; w < 5; w++) begin
      sb.push_back(ent(w, {8'(w + 8'h80), 8'(w + 8'h40)}));
      put(2*w, 8'(w + 8'h40), 0);
      put(2*w+1, 8'(w + 8'h80), 0);
    end
    g = 0;
    while (n_words - base < 3 && g < 200) begin
      @(negedge clk_sys);
      g++;
    end
    chk("rst_3words", n_words - base >= 3, 1);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("rst_mid_outputs", outs(), 0);
    sb.delete();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("rst_release_outputs", outs(), 0);

    // full 16 KB reload, acks held 4 cycles
    ack_dly = 1; ack_hold = 4;
    base = n_words;
    start_dl(8'd0);
    for (int i = 0; i < 8192; i++) begin
      lo = 8'(i) ^ 8'h5A;
      hi = 8'(i >> 8) ^ 8'(i * 3);
      sb.push_back(ent(i, {hi, lo}));
      put(2*i, lo, 0);
      put(2*i+1, hi, 0);
    end
    end_dl();
    wait_loaded("full");
    chk("full_count", n_words - base, 8192);
    chk("full_last_addr", last_addr, 13'h1FFF);
    chk("full_err", bios_err, 0);
    chk("full_sb", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bios_loader.md
# bios_loader

Streams a BIOS image from the HPS ioctl download channel into the Next186 `system` block's BIOS load port. It sits directly upstream of `system` in `emu`.
- Assembles byte pairs into little-endian 16-bit words and buffers them in a small FIFO.
- Presents each word with its word address to `system` using the BIOS_WR/BIOS_REQ handshake, and back-pressures HPS via `ioctl_wait`.
- Raises `bios_loaded` once the last word has been consumed; `emu` holds the CPU in reset until then.

## Interface
Parameters:
- AW, 13: word address width; image capacity is 2^AW words (16 KB).
- DEPTH, 8: FIFO depth in words; power of two, ≥4.
- INDEX, 8'd0: `ioctl_index` value that selects a BIOS download; other indices are ignored.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  HPS download active.
- ioctl_index  in  8  download target.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  registered back-pressure to HPS.
- bios_addr  out  AW  word address of the presented word.
- bios_din  out  16  presented word, {odd byte, even byte}.
- bios_wr  out  1  word valid / write request to `system`.
- bios_req  in  1  `system` acknowledge; a word is consumed on a rising edge.
- bios_loaded  out  1  image fully transferred; held until the next matching download.
- bios_err  out  2  sticky flags: [0] odd length, [1] overflow/oversize.

## Operation
**Reset values.** State=IDLE, FIFO empty, `ioctl_wait`=0, `bios_addr`=0, `bios_din`=0, `bios_wr`=0, `bios_loaded`=0, `bios_err`=0, pending-byte flag cleared.

**State machine (IDLE, LOAD, FLUSH, DONE):**
- IDLE/DONE → LOAD on the rising edge of `ioctl_download` (registered compare) when `ioctl_index`==INDEX.
  - On entry: clear FIFO, `bios_addr`, `bios_err`, the pending byte, and `bios_loaded`.
- LOAD → FLUSH on the falling edge of `ioctl_download`.
  - If an even byte is pending, push {8'h00, byte} and set `bios_err[0]`.
- FLUSH → DONE when the FIFO is empty, `bios_wr`=0 and `bios_req`=0. `bios_loaded` is set in the same cycle as the transition.
- A rising edge of `ioctl_download` with a non-matching index leaves the state unchanged.

**Byte assembly (LOAD only).**
- `ioctl_wr` with `ioctl_addr[0]`=0 latches the low byte.
- `ioctl_wr` with `ioctl_addr[0]`=1 pushes {`ioctl_dout`, low byte} together with word address `ioctl_addr[AW:1]`.
- Bytes with `ioctl_addr` ≥ 2^(AW+1) are dropped and set `bios_err[1]`.
- A push while the FIFO is full is dropped and sets `bios_err[1]`.

**Drain.**
- `bios_wr` is high whenever the FIFO head is valid and no acknowledge is outstanding. `bios_addr`/`bios_din` show the head entry and are stable while `bios_wr`=1.
- On a `bios_req` rising edge (registered edge detect) while `bios_wr`=1: pop the head and drive `bios_wr`=0 the next cycle.
- `bios_wr` re-asserts only after `bios_req` has been sampled low and the FIFO is non-empty.

**Back-pressure and arithmetic.**
- `ioctl_wait` = registered (count ≥ DEPTH−2), giving slack for the HPS stop latency.
- FIFO count is log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- A push and a pop in the same cycle leave the count unchanged.

## Timing
- Odd-byte `ioctl_wr` at cycle N → word in FIFO at N+1 → `bios_wr` high at N+2 if the FIFO was empty.
- `bios_req` rises at cycle M (sampled) → pop and `bios_wr`=0 at M+1. The next word is presented no earlier than the cycle after `bios_req` is sampled low.
- Minimum 3 cycles per word with a 1-cycle `bios_req` pulse.
- Last acknowledge falls → `bios_loaded` high within 2 cycles.
- `reset_n` low mid-transfer immediately returns every output to its reset value. The partial image is not resumed; a new download is required.

## Test plan
- **Basic load.** 4-byte download 11,22,33,44, index 0; `system` model pulses `bios_req` 2 cycles after each `bios_wr`.
  - Expect writes (0,16'h2211), (1,16'h4433).
  - Expect `bios_loaded`=1 ≤2 cycles after the final ack, `bios_err`=0.
- **Back-pressure.** DEPTH=8, model never acks.
  - `ioctl_wait` must be high once the count reaches 6.
  - Pushes 7 and 8 are accepted; a 9th forced push is dropped and sets `bios_err[1]`.
- **Odd length.** 3-byte image AA,BB,CC.
  - Expect words 16'hBBAA and 16'h00CC, `bios_err[0]`=1, `bios_loaded`=1.
- **Wrong index.** Download with index 1.
  - No `bios_wr` and `bios_loaded` unchanged. A subsequent index-0 download loads normally.
- **Reset and reload.** Assert `reset_n`=0 after 3 words, then release.
  - All outputs are 0. A full 16 KB reload ends with `bios_addr` last presented 13'h1FFF and `bios_loaded`=1.
- **Concurrent push/pop.** Back-to-back byte stream with every ack held 4 cycles.
  - Count never exceeds DEPTH, and no word is duplicated or lost: the checker compares all 8192 words.
